// File: rtl/sad_pkg.sv
// ============================================================================
// Module   : sad_pkg
// Purpose  : Shared types and helpers for the SAD stereo disparity search.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sad_pkg;

  // Search controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Pixel type for the default camera depth
  localparam int PIXEL_W_DEFAULT = 8;
  typedef logic [PIXEL_W_DEFAULT-1:0] pixel_t;

  // Width that holds a full-window SAD without overflow: every pixel
  // contributes at most 2^PIXEL_W-1, and there are K*K of them.
  function automatic int cost_width(input int pixel_w, input int kernel_size);
    return pixel_w + $clog2(kernel_size * kernel_size);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sad_window_cost.sv
// ============================================================================
// Module   : sad_window_cost
// Purpose  : Combinational K*K sum of absolute differences between two
//            equally laid-out pixel windows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_window_cost
  import sad_pkg::*;
#(
  parameter  int KERNEL_SIZE = 3,
  parameter  int PIXEL_W     = 8,
  localparam int NPIX        = KERNEL_SIZE * KERNEL_SIZE,
  localparam int COST_W      = cost_width(PIXEL_W, KERNEL_SIZE)
) (
  input  logic [NPIX*PIXEL_W-1:0] left_win_i,
  input  logic [NPIX*PIXEL_W-1:0] right_win_i,
  output logic [COST_W-1:0]       cost_o
);

  logic [PIXEL_W-1:0] absdiff_w [NPIX];

  // Per-pixel |L-R|: both differences are formed one bit wider so the sign
  // of L-R picks the non-negative one; its magnitude always fits PIXEL_W.
  for (genvar g = 0; g < NPIX; g++) begin : g_absdiff
    logic [PIXEL_W:0] l_minus_r_w;
    logic [PIXEL_W:0] r_minus_l_w;
    assign l_minus_r_w  = {1'b0, left_win_i[g*PIXEL_W +: PIXEL_W]}
                        - {1'b0, right_win_i[g*PIXEL_W +: PIXEL_W]};
    assign r_minus_l_w  = {1'b0, right_win_i[g*PIXEL_W +: PIXEL_W]}
                        - {1'b0, left_win_i[g*PIXEL_W +: PIXEL_W]};
    assign absdiff_w[g] = l_minus_r_w[PIXEL_W] ? r_minus_l_w[PIXEL_W-1:0]
                                               : l_minus_r_w[PIXEL_W-1:0];
  end

  // Accumulate the magnitudes; synthesis restructures this into a tree
  always_comb begin
    cost_o = '0;
    for (int i = 0; i < NPIX; i++) begin
      cost_o = cost_o + COST_W'(absdiff_w[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sad_disparity_search.sv
// ============================================================================
// Module   : sad_disparity_search
// Purpose  : Stereo block matcher. Each accepted left/right column pair is
//            shifted into window caches, then disparities 0..MAX_DISP-1 are
//            scored one per cycle and the lowest-SAD disparity is reported
//            with its cost and the column's screen coordinates.
// Options  : SAD_DISPARITY_UNIQUENESS_EN - also track the second-best cost
//            and only flag a result trustworthy when best and second-best
//            are at least UNIQ_MARGIN apart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_disparity_search
  import sad_pkg::*;
#(
  parameter  int KERNEL_SIZE = 3,
  parameter  int MAX_DISP    = 16,
  parameter  int PIXEL_W     = 8,
  parameter  int HCOUNT_W    = 11,
  parameter  int VCOUNT_W    = 10,
  parameter  int UNIQ_MARGIN = 32,
  localparam int DISP_W      = $clog2(MAX_DISP),
  localparam int COST_W      = cost_width(PIXEL_W, KERNEL_SIZE)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [KERNEL_SIZE*PIXEL_W-1:0]  left_data_in,
  input  logic [KERNEL_SIZE*PIXEL_W-1:0]  right_data_in,
  input  logic [HCOUNT_W-1:0]             hcount_in,
  input  logic [VCOUNT_W-1:0]             vcount_in,
  input  logic                            data_valid_in,
  output logic                            ready_out,
  output logic                            overrun_out,
  output logic                            data_valid_out,
  output logic [HCOUNT_W-1:0]             hcount_out,
  output logic [VCOUNT_W-1:0]             vcount_out,
  output logic [DISP_W-1:0]               disparity_out,
  output logic [COST_W-1:0]               cost_out,
  output logic                            disp_ok_out
);

  localparam int COL_W    = KERNEL_SIZE * PIXEL_W;
  localparam int NCOL_R   = KERNEL_SIZE + MAX_DISP - 1;
  localparam int IDX_W    = $clog2(NCOL_R);
  localparam int FILL_W   = $clog2(NCOL_R + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NCOL_R);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(MAX_DISP - 1);

  // Reject configurations outside the supported window/search range
  if (KERNEL_SIZE < 3 || KERNEL_SIZE > 7 || (KERNEL_SIZE % 2) == 0 ||
      MAX_DISP < 2 || MAX_DISP > 64 || UNIQ_MARGIN < 0) begin : g_param_check
    $error("sad_disparity_search: parameter out of supported range");
  end

  // Column caches; index 0 holds the most recently accepted column
  logic [KERNEL_SIZE-1:0][COL_W-1:0] lcache_q;
  logic [NCOL_R-1:0][COL_W-1:0]      rcache_q;

  state_e                state_q, state_d;
  logic [DISP_W-1:0]     d_q, d_d;
  logic [COST_W-1:0]     best_cost_q, best_cost_d;
  logic [DISP_W-1:0]     best_disp_q, best_disp_d;
  logic [FILL_W-1:0]     fill_q;
  logic [HCOUNT_W-1:0]   hcount_q;
  logic [VCOUNT_W-1:0]   vcount_q;

  logic                  data_valid_q;
  logic                  overrun_q;
  logic [HCOUNT_W-1:0]   hcount_out_q;
  logic [VCOUNT_W-1:0]   vcount_out_q;
  logic [DISP_W-1:0]     disp_out_q;
  logic [COST_W-1:0]     cost_out_q;
  logic                  ok_q, ok_d;

  logic                  ready_w;
  logic                  accept_w;
  logic                  finish_w;
  logic [COST_W-1:0]     cost_w;
  logic [KERNEL_SIZE-1:0][COL_W-1:0] right_win_w;

`ifdef SAD_DISPARITY_UNIQUENESS_EN
  localparam logic [COST_W-1:0] MARGIN = COST_W'(UNIQ_MARGIN);
  logic [COST_W-1:0]     second_q, second_d;
`endif

  // A new column can be taken in every state except while searching
  assign ready_w  = (state_q != SEARCH);
  assign accept_w = data_valid_in && ready_w;

  // Right window for the current disparity: cache columns d..d+K-1
  for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_rwin
    logic [IDX_W-1:0] idx_w;
    assign idx_w           = IDX_W'(d_q) + IDX_W'(gi);
    assign right_win_w[gi] = rcache_q[idx_w];
  end

  sad_window_cost #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .PIXEL_W     (PIXEL_W)
  ) u_cost (
    .left_win_i  (lcache_q),
    .right_win_i (right_win_w),
    .cost_o      (cost_w)
  );

  // Controller next state and running minimum over the disparity sweep
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    best_cost_d = best_cost_q;
    best_disp_d = best_disp_q;
    finish_w    = 1'b0;
`ifdef SAD_DISPARITY_UNIQUENESS_EN
    second_d    = second_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept_w) begin
          state_d     = SEARCH;
          d_d         = '0;
          best_cost_d = '1;
`ifdef SAD_DISPARITY_UNIQUENESS_EN
          second_d    = '1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        // Strict compare: on a tie the earlier (smaller) disparity wins
        if (cost_w < best_cost_q) begin
          best_cost_d = cost_w;
          best_disp_d = d_q;
`ifdef SAD_DISPARITY_UNIQUENESS_EN
          second_d    = best_cost_q;
        end else if (cost_w < second_q) begin
          second_d    = cost_w;
`endif
        end
        if (d_q == DISP_LAST) begin
          state_d  = DONE;
          finish_w = 1'b1;
        end else begin
          d_d = d_q + DISP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Trust flag uses the final minimum, which is settled in best_cost_d
  // on the last search cycle.
`ifdef SAD_DISPARITY_UNIQUENESS_EN
  assign ok_d = (fill_q == FILL_FULL) && ((second_d - best_cost_d) >= MARGIN);
`else
  assign ok_d = (fill_q == FILL_FULL);
`endif

  // Search controller registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      d_q         <= '0;
      best_cost_q <= '0;
      best_disp_q <= '0;
`ifdef SAD_DISPARITY_UNIQUENESS_EN
      second_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      best_cost_q <= best_cost_d;
      best_disp_q <= best_disp_d;
`ifdef SAD_DISPARITY_UNIQUENESS_EN
      second_q    <= second_d;
`endif
    end
  end

  // Shift accepted columns into the caches and latch their coordinates
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lcache_q <= '0;
      rcache_q <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else if (accept_w) begin
      lcache_q <= {lcache_q[KERNEL_SIZE-2:0], left_data_in};
      rcache_q <= {rcache_q[NCOL_R-2:0], right_data_in};
      hcount_q <= hcount_in;
      vcount_q <= vcount_in;
    end
  end

  // Count valid columns since the start of the line, saturating once the
  // whole right cache holds real image data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fill_q <= '0;
    end else if (accept_w) begin
      if (hcount_in == '0) begin
        fill_q <= FILL_W'(1);
      end else if (fill_q != FILL_FULL) begin
        fill_q <= fill_q + FILL_W'(1);
      end
    end
  end

  // Result and status outputs; result fields hold until the next result
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      hcount_out_q <= '0;
      vcount_out_q <= '0;
      disp_out_q   <= '0;
      cost_out_q   <= '0;
      ok_q         <= 1'b0;
    end else begin
      data_valid_q <= finish_w;
      overrun_q    <= data_valid_in && !ready_w;
      if (finish_w) begin
        hcount_out_q <= hcount_q;
        vcount_out_q <= vcount_q;
        disp_out_q   <= best_disp_d;
        cost_out_q   <= best_cost_d;
        ok_q         <= ok_d;
      end
    end
  end

  assign ready_out      = ready_w;
  assign overrun_out    = overrun_q;
  assign data_valid_out = data_valid_q;
  assign hcount_out     = hcount_out_q;
  assign vcount_out     = vcount_out_q;
  assign disparity_out  = disp_out_q;
  assign cost_out       = cost_out_q;
  assign disp_ok_out    = ok_q;

endmodule

`default_nettype wire

// File: tb/tb_sad_disparity_search.sv
// ============================================================================
// Module   : tb_sad_disparity_search
// Purpose  : Self-checking bench for sad_disparity_search (K=3, MAX_DISP=8).
//            A reference model keeps the column history in queues and scores
//            every disparity at once; directed and random columns are fed
//            and each result is compared against the model.
// Options  : SAD_DISPARITY_UNIQUENESS_EN - model also applies the
//            best/second-best margin rule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sad_disparity_search;

  localparam int K      = 3;
  localparam int MD     = 8;
  localparam int PW     = 8;
  localparam int HW     = 11;
  localparam int VW     = 10;
  localparam int UM     = 32;
  localparam int DW     = $clog2(MD);
  localparam int CW     = PW + $clog2(K * K);
  localparam int COL_W  = K * PW;
  localparam int NCOL_R = K + MD - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [COL_W-1:0] left_data  = '0;
  logic [COL_W-1:0] right_data = '0;
  logic [HW-1:0]    hcount = '0;
  logic [VW-1:0]    vcount = '0;
  logic             dvin = 1'b0;
  logic             ready_o, ovr_o, dv_o, ok_o;
  logic [HW-1:0]    hcount_o;
  logic [VW-1:0]    vcount_o;
  logic [DW-1:0]    disp_o;
  logic [CW-1:0]    cost_o;

  int n_checks = 0;
  int n_errors = 0;
  int last_cost = 0;

  // Reference model state
  logic [COL_W-1:0] lhist[$];
  logic [COL_W-1:0] rhist[$];
  int               fill_m = 0;

  sad_disparity_search #(
    .KERNEL_SIZE (K),
    .MAX_DISP    (MD),
    .PIXEL_W     (PW),
    .HCOUNT_W    (HW),
    .VCOUNT_W    (VW),
    .UNIQ_MARGIN (UM)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .left_data_in   (left_data),
    .right_data_in  (right_data),
    .hcount_in      (hcount),
    .vcount_in      (vcount),
    .data_valid_in  (dvin),
    .ready_out      (ready_o),
    .overrun_out    (ovr_o),
    .data_valid_out (dv_o),
    .hcount_out     (hcount_o),
    .vcount_out     (vcount_o),
    .disparity_out  (disp_o),
    .cost_out       (cost_o),
    .disp_ok_out    (ok_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [COL_W-1:0] uniform_col(input int v);
    logic [COL_W-1:0] c;
    for (int p = 0; p < K; p++) c[p*PW +: PW] = PW'(v);
    return c;
  endfunction

  function automatic logic [COL_W-1:0] rand_col(input int maxv);
    logic [COL_W-1:0] c;
    for (int p = 0; p < K; p++) c[p*PW +: PW] = PW'($urandom_range(0, maxv));
    return c;
  endfunction

  function automatic int pix(input logic [COL_W-1:0] c, input int p);
    return int'(c[p*PW +: PW]);
  endfunction

  // Columns never written since reset read as zero
  function automatic logic [COL_W-1:0] lcol(input int j);
    return (j < lhist.size()) ? lhist[j] : '0;
  endfunction

  function automatic logic [COL_W-1:0] rcol(input int j);
    return (j < rhist.size()) ? rhist[j] : '0;
  endfunction

  task automatic model_reset();
    lhist.delete();
    rhist.delete();
    fill_m = 0;
  endtask

  task automatic model_accept(input logic [COL_W-1:0] l, input logic [COL_W-1:0] r, input int h);
    lhist.push_front(l);
    rhist.push_front(r);
    if (lhist.size() > K) void'(lhist.pop_back());
    if (rhist.size() > NCOL_R) void'(rhist.pop_back());
    if (h == 0) fill_m = 1;
    else if (fill_m < NCOL_R) fill_m++;
  endtask

  // Score all disparities, pick the lowest cost (first one on a tie)
  task automatic model_result(output int disp, output int cost, output bit ok);
    int costs[MD];
    int sorted[$];
    int a, b;
    for (int d = 0; d < MD; d++) begin
      costs[d] = 0;
      for (int i = 0; i < K; i++)
        for (int p = 0; p < K; p++) begin
          a = pix(lcol(i), p);
          b = pix(rcol(d + i), p);
          costs[d] += (a > b) ? a - b : b - a;
        end
    end
    disp = 0;
    cost = costs[0];
    for (int d = 1; d < MD; d++)
      if (costs[d] < cost) begin
        cost = costs[d];
        disp = d;
      end
    ok = (fill_m == NCOL_R);
`ifdef SAD_DISPARITY_UNIQUENESS_EN
    for (int d = 0; d < MD; d++) sorted.push_back(costs[d]);
    sorted.sort();
    ok = ok && ((sorted[1] - sorted[0]) >= UM);
`endif
  endtask

  // Called at a negedge with ready_out high; returns at the negedge of the
  // result cycle so the next call can exercise a back-to-back accept.
  task automatic do_column(input logic [COL_W-1:0] l, input logic [COL_W-1:0] r,
                           input int h, input int v, input bit inject, input string tag);
    int  exp_d, exp_c, lat, ovr, rdy_hi;
    bit  exp_ok, seen;
    left_data  = l;
    right_data = r;
    hcount     = HW'(h);
    vcount     = VW'(v);
    dvin       = 1'b1;
    model_accept(l, r, h);
    model_result(exp_d, exp_c, exp_ok);
    @(posedge clk);
    #1 dvin = 1'b0;
    lat = 0; ovr = 0; rdy_hi = 0; seen = 0;
    for (int i = 1; i <= MD + 4 && !seen; i++) begin
      @(negedge clk);
      if (ovr_o) ovr++;
      if (dv_o) begin
        seen = 1;
        lat  = i;
      end else if (ready_o) begin
        rdy_hi++;
      end
      if (inject && i == 3) begin
        left_data  = ~l;
        right_data = ~r;
        hcount     = ~HW'(h);
        vcount     = ~VW'(v);
        dvin       = 1'b1;
      end
      if (inject && i == 4) dvin = 1'b0;
    end
    check({tag, " latency"}, lat, MD + 1);
    check({tag, " ready_low_in_search"}, rdy_hi, 0);
    check({tag, " overrun_pulses"}, ovr, inject ? 1 : 0);
    check({tag, " ready_in_done"}, ready_o, 1);
    check({tag, " disparity"}, disp_o, exp_d);
    check({tag, " cost"}, cost_o, exp_c);
    check({tag, " disp_ok"}, ok_o, exp_ok);
    check({tag, " hcount"}, hcount_o, h);
    check({tag, " vcount"}, vcount_o, v);
    last_cost = exp_c;
  endtask

  // One idle cycle: the strobe must have dropped and the result must hold
  task automatic idle_gap();
    @(negedge clk);
    check("idle dv_pulse_width", dv_o, 0);
    check("idle ready", ready_o, 1);
    check("idle cost_hold", cost_o, last_cost);
  endtask

  initial begin
    int sawdv;
    int h;

    // Power-on reset state
    repeat (2) @(negedge clk);
    check("reset ready", ready_o, 1);
    check("reset dv", dv_o, 0);
    check("reset ovr", ovr_o, 0);
    check("reset cost", cost_o, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Uniform identical images: disparity 0, cost 0, trusted once filled
    for (int x = 0; x < 12; x++)
      do_column(uniform_col(100), uniform_col(100), x, 5, 1'b0, "uniform");
    idle_gap();

    // Right image is the left image shifted by three columns
    for (int x = 0; x < 16; x++)
      do_column(uniform_col(7 * x), uniform_col(7 * (x + 3)), x, 6, 1'b0, "ramp");
    check("ramp final disparity", disp_o, 3);
    check("ramp final cost", cost_o, 0);
    idle_gap();

    // Large negative difference must not wrap: 9 * |10-250|
    for (int x = 0; x < 12; x++)
      do_column(uniform_col(10), uniform_col(250), x, 7, 1'b0, "abs");
    check("abs cost_2160", cost_o, 2160);
    check("abs disparity", disp_o, 0);
    idle_gap();

    // Reset asserted mid-search, between clock edges
    left_data  = uniform_col(50);
    right_data = uniform_col(60);
    hcount     = HW'(3);
    dvin       = 1'b1;
    @(posedge clk);
    #1 dvin = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst ready", ready_o, 1);
    check("midrst dv", dv_o, 0);
    check("midrst cost", cost_o, 0);
    check("midrst hcount", hcount_o, 0);
    check("midrst vcount", vcount_o, 0);
    check("midrst ok", ok_o, 0);
    sawdv = 0;
    repeat (MD + 2) begin
      @(negedge clk);
      if (dv_o) sawdv++;
    end
    check("midrst no_result", sawdv, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Strobes during search are dropped and flagged
    for (int x = 0; x < 12; x++)
      do_column(uniform_col(7 * x), uniform_col(7 * (x + 3)), x, 9, (x % 3) == 1, "overrun");
    idle_gap();

    // Random columns, line restarts, back-to-back and gapped accepts
    h = 0;
    for (int n = 0; n < 60; n++) begin
      logic [COL_W-1:0] l, r;
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        l = rand_col(255);
        r = rand_col(255);
      end else if (mode == 1) begin
        l = rand_col(3);
        r = rand_col(3);
      end else begin
        l = rand_col(255);
        r = (rhist.size() > 2) ? lhist[0] : rand_col(255);
      end
      do_column(l, r, h, $urandom_range(0, 1023), $urandom_range(0, 5) == 0, "random");
      if ($urandom_range(0, 3) == 0) idle_gap();
      h = ($urandom_range(0, 14) == 0 || h >= 20) ? 0 : h + 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sad_disparity_search.md
Name: sad_disparity_search

Overview:
- Parametrised successor stereo block matcher.
- Each accepted column pair (left and right, KERNEL_SIZE pixels each) is shifted into window caches.
- The block then searches disparities 0..MAX_DISP-1 at one per cycle, using true absolute-difference SAD, and emits the best disparity with its cost and screen coordinates.
- Sits between the dual-camera line buffers and the depth colouriser.

Parameters:
- KERNEL_SIZE, 3, square window side (odd, 3..7)
- MAX_DISP, 16, number of disparities searched (2..64)
- PIXEL_W, 8, pixel width in bits
- HCOUNT_W, 11, hcount width
- VCOUNT_W, 10, vcount width
- UNIQ_MARGIN, 32, minimum cost gap between best and second-best (used only with the optional feature)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- left_data_in  in  KERNEL_SIZE*PIXEL_W  left column; element 0 is the top row
- right_data_in  in  KERNEL_SIZE*PIXEL_W  right column, same layout
- hcount_in  in  HCOUNT_W  column coordinate
- vcount_in  in  VCOUNT_W  row coordinate
- data_valid_in  in  1  column strobe
- ready_out  out  1  high when a column can be accepted
- overrun_out  out  1  one-cycle pulse: strobe arrived while not ready
- data_valid_out  out  1  one-cycle result strobe
- hcount_out  out  HCOUNT_W  coordinate echoed from the accepted column
- vcount_out  out  VCOUNT_W  coordinate echoed from the accepted column
- disparity_out  out  clog2(MAX_DISP)  best disparity
- cost_out  out  COST_W  best SAD cost; COST_W = PIXEL_W + clog2(KERNEL_SIZE*KERNEL_SIZE)
- disp_ok_out  out  1  result is trustworthy

Behaviour:
- Reset (async): state IDLE, all caches 0, fill counter 0; ready_out=1; all other outputs 0.
- Accept: a column is accepted when data_valid_in && ready_out at clock edge T.
  - Left cache: KERNEL_SIZE columns. Right cache: KERNEL_SIZE+MAX_DISP-1 columns. Column 0 is the newest; both caches shift by one column.
  - Coordinates are latched.
- Strobe while not ready: the column is ignored (caches and coordinates unchanged) and overrun_out pulses next cycle.
- Cost for disparity d: left window = left cache columns 0..K-1; right window = right cache columns d..d+K-1.
  - cost = sum over K*K pixels of |L-R|, computed unsigned in PIXEL_W+1 bits, magnitude PIXEL_W bits.
  - Sum is COST_W bits and cannot overflow.
- FSM:
  - IDLE: ready_out=1; on accept go to SEARCH with d=0, best cost = all ones.
  - SEARCH: one disparity per cycle, cycles T+1..T+MAX_DISP.
    - Update the best when cost < best, strictly, so ties keep the smaller d.
    - After d=MAX_DISP-1, go to DONE.
  - DONE: register outputs; data_valid_out=1 for exactly one cycle (T+MAX_DISP+1); ready_out=1 in that same cycle.
    - A same-cycle accept goes straight to SEARCH; otherwise go to IDLE.
- Latency and throughput: latency MAX_DISP+1 cycles; throughput one column per MAX_DISP+1 cycles.
- ready_out=0 throughout SEARCH.
- Fill counter (saturates at K+MAX_DISP-1):
  - An accept with hcount_in==0 sets it to 1; other accepts increment it.
  - disp_ok_out = (fill == K+MAX_DISP-1) at output time.
  - Invalid columns still produce a result with disparity_out/cost_out as computed.
- Outputs other than data_valid_out/overrun_out hold their last value between results.
- Reset mid-SEARCH: the result is abandoned; no data_valid_out; fill counter cleared.

Optional Feature:
- Macro: SAD_DISPARITY_UNIQUENESS_EN.
- Defined:
  - SEARCH also tracks second-best. When cost < best: second <= best, best <= cost. Else when cost < second: second <= cost.
  - disp_ok_out additionally requires (second - best) >= UNIQ_MARGIN.
- Undefined: no second-best register; disp_ok_out depends on fill only.
- Ports are identical in both builds.

Decomposition:
- Package sad_pkg:
  - state enum {IDLE, SEARCH, DONE}
  - cost-width function clog2-based
  - pixel_t
- Sub-module sad_window_cost: combinational K*K absolute-difference adder tree, parametrised by KERNEL_SIZE and PIXEL_W. It is instantiated once and fed through a mux on d.

Test Plan (K=3, MAX_DISP=8, PIXEL_W=8):
- Assert rst_in mid-cycle -> outputs cleared immediately; ready_out=1, data_valid_out=0.
- 12 columns of left=right=100, hcount 0..11 -> each result has disparity 0, cost 0; disp_ok_out=0 for hcount 0..8 and 1 for hcount 9..11; data_valid_out exactly 9 cycles after each accept.
- Left column x has all pixels 7x, right column x has all pixels 7(x+3), hcount 0..15 -> from hcount 10 on, disparity 3, cost 0, disp_ok_out=1.
- All left pixels 10, all right pixels 250 -> cost_out=2160 (9*240), disparity 0; checks the absolute difference, no wrap.
- Strobe data_valid_in during SEARCH with a distinct pattern -> overrun_out pulses once; the following result is identical to one without the strobe.
- With SAD_DISPARITY_UNIQUENESS_EN and uniform image -> second=best=0, so disp_ok_out=0 despite full fill; the shifted-ramp case gives disp_ok_out=1.
